// File: rtl/memory_island_port_limiter.sv
// rtl/memory_island_port_limiter.sv - request cut FIFO and outstanding-request limiter for one memory-island port
module memory_island_port_limiter #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned StrbWidth      = DataWidth / 8,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RspReg         = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [StrbWidth-1:0] strb_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [StrbWidth-1:0] mem_strb_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 busy_o,
    output logic                 rsp_err_o
);

    localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
    localparam int unsigned EntryWidth = AddrWidth + 1 + DataWidth + StrbWidth;

    if (MaxOutstanding < 1) begin : g_bad_max_outstanding
        $error("MaxOutstanding must be at least 1");
    end

    logic [EntryWidth-1:0] entry_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            occ_q;
    logic [CntWidth-1:0]   count_q;
    logic                  rsp_err_q;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic below_limit;
    logic rsp_counted;

    // All upstream/downstream handshakes are built from registered state only,
    // so mem_gnt_i never reaches gnt_o combinationally.
    assign empty       = (occ_q == 2'd0);
    assign full        = (occ_q == 2'd2);
    assign below_limit = (count_q < CntWidth'(MaxOutstanding));
    assign gnt_o       = !full;
    assign mem_req_o   = !empty && below_limit;
    assign push        = req_i && gnt_o;
    assign pop         = mem_req_o && mem_gnt_i;
    assign rsp_counted = mem_rvalid_i && (count_q != '0);
    assign busy_o      = !empty || (count_q != '0);
    assign rsp_err_o   = rsp_err_q;

    assign {mem_addr_o, mem_we_o, mem_wdata_o, mem_strb_o} = entry_q[rd_ptr_q];

    // Two-entry request FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= {addr_i, we_i, wdata_i, strb_i};
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Outstanding counter; a response with nothing outstanding flags an error instead of underflowing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case ({pop, rsp_counted})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
            if (mem_rvalid_i && (count_q == '0)) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    if (RspReg != 0) begin : g_rsp_reg
        logic                 rvalid_q;
        logic [DataWidth-1:0] rdata_q;

        // Registered response path; data is held between responses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= mem_rvalid_i;
                if (mem_rvalid_i) begin
                    rdata_q <= mem_rdata_i;
                end
            end
        end

        assign rvalid_o = rvalid_q;
        assign rdata_o  = rdata_q;
    end else begin : g_rsp_comb
        assign rvalid_o = mem_rvalid_i;
        assign rdata_o  = mem_rdata_i;
    end

endmodule

// File: tb/tb_memory_island_port_limiter.sv
// tb/tb_memory_island_port_limiter.sv - directed and randomized checks of memory_island_port_limiter against a queue model
module tb_memory_island_port_limiter;

    localparam int MAXO = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  strb_i = '0;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_strb_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        busy_o;
    logic        rsp_err_o;

    int tests = 0;
    int fails = 0;

    req_t        m_q[$];
    int          m_out = 0;
    bit          m_err = 0;
    bit          m_rvalid = 0;
    logic [63:0] m_rdata = '0;
    logic [31:0] issued[$];

    memory_island_port_limiter #(
        .AddrWidth(32), .DataWidth(64), .StrbWidth(8), .MaxOutstanding(MAXO), .RspReg(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .strb_i(strb_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out = 0;
        m_err = 0;
        m_rvalid = 0;
        m_rdata = '0;
    endtask

    // Compare every output against the model, advance the model by the current inputs, then move to the next falling edge.
    task automatic cycle();
        bit   exp_req;
        bit   do_push;
        bit   do_pop;
        req_t r;
        exp_req = (m_q.size() > 0) && (m_out < MAXO);
        check("gnt", gnt_o, m_q.size() < 2);
        check("mem_req", mem_req_o, exp_req);
        if (exp_req) begin
            check("mem_addr", mem_addr_o, m_q[0].addr);
            check("mem_we", mem_we_o, m_q[0].we);
            check("mem_wdata", mem_wdata_o, m_q[0].wdata);
            check("mem_strb", mem_strb_o, m_q[0].strb);
        end
        check("rvalid", rvalid_o, m_rvalid);
        check("rdata", rdata_o, m_rdata);
        check("busy", busy_o, (m_q.size() > 0) || (m_out != 0));
        check("rsp_err", rsp_err_o, m_err);
        check("count", 64'(dut.count_q), 64'(m_out));
        if (mem_req_o && mem_gnt_i) issued.push_back(mem_addr_o);
        do_push = req_i && (m_q.size() < 2);
        do_pop  = exp_req && mem_gnt_i;
        r.addr = addr_i; r.we = we_i; r.wdata = wdata_i; r.strb = strb_i;
        if (do_pop) m_q.delete(0);
        if (do_push) m_q.push_back(r);
        if (mem_rvalid_i) begin
            if (m_out == 0) m_err = 1;
            else m_out = m_out - 1;
        end
        if (do_pop) m_out = m_out + 1;
        m_rvalid = mem_rvalid_i;
        if (mem_rvalid_i) m_rdata = mem_rdata_i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [7:0] s);
        bit acc;
        acc = 0;
        req_i = 1'b1; addr_i = a; we_i = w; wdata_i = d; strb_i = s;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = gnt_o;
            cycle();
        end
        req_i = 1'b0;
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        req_i = 1'b0;
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            mem_rvalid_i = (m_out > 0);
            mem_rdata_i = {$urandom, $urandom};
            cycle();
            done = (m_q.size() == 0) && (m_out == 0);
        end
        mem_rvalid_i = 1'b0;
        mem_gnt_i = 1'b0;
        cycle();
        check("drain_done", done, 1'b1);
    endtask

    task automatic single_read();
        check("s1_gnt", gnt_o, 1'b1);
        req_i = 1'b1; addr_i = 32'h100; we_i = 1'b0; wdata_i = '0; strb_i = 8'hFF;
        cycle();
        req_i = 1'b0; mem_gnt_i = 1'b1;
        check("s1_mem_req", mem_req_o, 1'b1);
        check("s1_mem_addr", mem_addr_o, 32'h100);
        cycle();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD;
        cycle();
        mem_rvalid_i = 1'b0;
        check("s1_rvalid", rvalid_o, 1'b1);
        check("s1_rdata", rdata_o, 64'hDEAD);
        check("s1_busy", busy_o, 1'b0);
        cycle();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_gnt", gnt_o, 1'b1);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_rdata", rdata_o, 64'h0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", rsp_err_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();

        // Scenario 1: single read
        single_read();

        // Scenario 2: downstream stall then in-order release
        issued.delete();
        mem_gnt_i = 1'b0;
        send(32'h0, 1'b0, 64'h0, 8'hFF);
        send(32'h8, 1'b1, 64'h1111, 8'h0F);
        req_i = 1'b1; addr_i = 32'h10; we_i = 1'b0; wdata_i = '0; strb_i = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            check("s2_gnt_low", gnt_o, 1'b0);
            check("s2_head_stable", mem_addr_o, 32'h0);
            cycle();
        end
        mem_gnt_i = 1'b1;
        send(32'h10, 1'b0, 64'h0, 8'hFF);
        drain();
        check("s2_issue_count", issued.size(), 3);
        if (issued.size() == 3) begin
            check("s2_issue0", issued[0], 32'h0);
            check("s2_issue1", issued[1], 32'h8);
            check("s2_issue2", issued[2], 32'h10);
        end

        // Scenario 3: outstanding limit
        issued.delete();
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) send(32'h200 + 32'(i * 8), 1'b0, 64'h0, 8'hFF);
        for (int k = 0; k < 3; k++) cycle();
        check("s3_grants", issued.size(), MAXO);
        check("s3_mem_req_off", mem_req_o, 1'b0);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h33;
        cycle();
        mem_rvalid_i = 1'b0;
        check("s3_mem_req_back", mem_req_o, 1'b1);
        drain();

        // Scenario 4: simultaneous push/pop and grant/response
        mem_gnt_i = 1'b1;
        send(32'h300, 1'b0, 64'h0, 8'hFF);
        send(32'h308, 1'b0, 64'h0, 8'hFF);
        check("s4_gnt_pushpop", gnt_o, 1'b1);
        check("s4_occ_pushpop", 64'(dut.occ_q), 64'd1);
        cycle();
        mem_gnt_i = 1'b0;
        send(32'h310, 1'b0, 64'h0, 8'hFF);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h44;
        cycle();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
        check("s4_count_same", 64'(dut.count_q), 64'd2);
        drain();

        // Scenario 5: spurious response when idle
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h55;
        cycle();
        mem_rvalid_i = 1'b0;
        check("s5_rvalid", rvalid_o, 1'b1);
        check("s5_rdata", rdata_o, 64'h55);
        check("s5_err", rsp_err_o, 1'b1);
        check("s5_count", 64'(dut.count_q), 64'd0);
        cycle();
        check("s5_err_held", rsp_err_o, 1'b1);
        single_read();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            req_i = ($urandom_range(0, 1) == 1);
            addr_i = $urandom; we_i = $urandom_range(0, 1) == 1;
            wdata_i = {$urandom, $urandom}; strb_i = 8'($urandom);
            mem_gnt_i = ($urandom_range(0, 2) != 0);
            mem_rvalid_i = (m_out > 0) && ($urandom_range(0, 2) == 0);
            mem_rdata_i = {$urandom, $urandom};
            cycle();
        end
        drain();

        // Scenario 6: reset mid-operation
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h400 + 32'(i * 8), 1'b0, 64'h0, 8'hFF);
        cycle();
        mem_gnt_i = 1'b0;
        send(32'h500, 1'b0, 64'h0, 8'hFF);
        send(32'h508, 1'b0, 64'h0, 8'hFF);
        check("s6_pre_busy", busy_o, 1'b1);
        check("s6_pre_count", 64'(dut.count_q), 64'd3);
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h66;
        #2;
        rst_ni = 1'b0;
        #1;
        check("s6_mem_req", mem_req_o, 1'b0);
        check("s6_rvalid", rvalid_o, 1'b0);
        check("s6_busy", busy_o, 1'b0);
        check("s6_gnt", gnt_o, 1'b1);
        check("s6_err", rsp_err_o, 1'b0);
        mem_rvalid_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        single_read();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
